alu: RTL and testbench

- Registered 16-bit integer ALU for the RISC datapath's execute stage.
- Takes two operands and a 3-bit operation select, and produces the result one clock later.
- Also produces a zero flag.
- Has a single-cycle, valid-qualified pipeline register with no back-pressure.

---
 rtl/alu.sv | 156 +++++++++++++++
 tb/tb_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu: registered integer ALU for the execute stage of the RISC datapath.
//
// Samples a, b and alu_sel on a rising clk edge where in_valid is high and
// presents the result, zero flag and out_valid one cycle later. No
// back-pressure: every accepted operation yields one out_valid pulse. With
// in_valid low, out_valid drops and result/zero_flag hold. All arithmetic is
// unsigned modulo 2^WIDTH.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 4)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands/alu_sel valid this cycle
//   a          operand A
//   b          operand B / shift amount (full WIDTH bits)
//   alu_sel    0 ADD, 1 SUB, 2 NOT, 3 SHL, 4 SHR, 5 AND, 6 OR, 7 CMP
//   out_valid  result/flags valid
//   result     registered result
//   zero_flag  high when the registered result is zero
//
// Optional build macro ALU_EXT_FLAGS_EN adds carry_flag, neg_flag and
// ovf_flag, registered alongside result.
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
`ifdef ALU_EXT_FLAGS_EN
  ,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             ovf_flag
`endif
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOT = 3'd2,
    OP_SHL = 3'd3,
    OP_SHR = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             valid_q;

  assign op = op_e'(alu_sel);

  // SystemVerilog shifts by an amount >= the operand width yield zero, which
  // gives the b >= WIDTH -> 0 behaviour without an explicit range check.
  always_comb begin
    result_d = '0;
    unique case (op)
      OP_ADD: result_d = a + b;
      OP_SUB: result_d = a - b;
      OP_NOT: result_d = ~a;
      OP_SHL: result_d = a << b;
      OP_SHR: result_d = a >> b;
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_CMP: begin
        result_d[0] = (a < b);
        result_d[1] = (a == b);
        result_d[2] = (a > b);
      end
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

`ifdef ALU_EXT_FLAGS_EN
  logic [WIDTH:0] sum_x, diff_x, shl_x, shr_x;
  logic           carry_d, neg_d, ovf_d;
  logic           carry_q, neg_q, ovf_q;

  // One extra bit on each side catches the carry/borrow or the last bit
  // shifted out. Shifting the widened operand by b > WIDTH clears that extra
  // bit too, so the "0 if b > WIDTH" rule falls out naturally.
  always_comb begin
    sum_x   = {1'b0, a} + {1'b0, b};
    diff_x  = {1'b0, a} - {1'b0, b};
    shl_x   = {1'b0, a} << b;
    shr_x   = {a, 1'b0} >> b;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    neg_d   = result_d[WIDTH-1];
    unique case (op)
      OP_ADD: begin
        carry_d = sum_x[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (result_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        carry_d = diff_x[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (result_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL:  carry_d = shl_x[WIDTH];
      OP_SHR:  carry_d = shr_x[0];
      default: begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_valid) begin
      carry_q <= carry_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry_flag = carry_q;
  assign neg_flag   = neg_q;
  assign ovf_flag   = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu: directed self-checking bench for alu. Expected results are pushed
// to a scoreboard queue when an operation is driven and popped when the DUT
// raises out_valid. Define ALU_EXT_FLAGS_EN for both files to cover the
// extended flags.
// ---------------------------------------------------------------------------
module tb_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   alu_sel = 3'd0;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero_flag;
`ifdef ALU_EXT_FLAGS_EN
  logic         carry_flag, neg_flag, ovf_flag;
`endif

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .result    (result),
    .zero_flag (zero_flag)
`ifdef ALU_EXT_FLAGS_EN
    ,
    .carry_flag(carry_flag),
    .neg_flag  (neg_flag),
    .ovf_flag  (ovf_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] last_res;
  logic         last_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one valid op at the falling edge, then check it one edge later.
  task automatic op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                    input logic [2:0] sel, input logic [W-1:0] exp_res);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a        = ai;
    b        = bi;
    alu_sel  = sel;
    e.res    = exp_res;
    e.zero   = (exp_res == '0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_res"}, 32'(result), 32'(e.res));
        chk({tag, "_zero"}, 32'(zero_flag), 32'(e.zero));
        last_res  = e.res;
        last_zero = e.zero;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = $urandom();
      b        = $urandom();
      alu_sel  = 3'($urandom_range(7, 0));
      @(posedge clk);
      #1;
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_res", 32'(result), 32'(last_res));
      chk("idle_zero", 32'(zero_flag), 32'(last_zero));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted with a valid op pending: outputs clear before any edge.
    in_valid = 1'b1;
    a        = 16'd10;
    b        = 16'd5;
    alu_sel  = 3'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    last_res  = '0;
    last_zero = 1'b0;

    op("add", 16'd10, 16'd5, 3'd0, 16'd15);
    idle(3);
    op("sub", 16'd15, 16'd8, 3'd1, 16'd7);
    op("sub_wrap", 16'd10, 16'd20, 3'd1, 16'hFFF6);
`ifdef ALU_EXT_FLAGS_EN
    chk("sub_wrap_borrow", 32'(carry_flag), 32'd1);
    chk("sub_wrap_neg", 32'(neg_flag), 32'd1);
    chk("sub_wrap_ovf", 32'(ovf_flag), 32'd0);
`endif
    op("not", 16'd0, 16'd1234, 3'd2, 16'hFFFF);
    op("or", 16'd45, 16'd45, 3'd6, 16'd45);
    op("and", 16'd30, 16'd15, 3'd5, 16'd14);
    op("cmp_lt", 16'd100, 16'd200, 3'd7, 16'h0001);
    op("cmp_eq", 16'd7, 16'd7, 3'd7, 16'h0002);
    op("cmp_gt", 16'd9, 16'd3, 3'd7, 16'h0004);
    op("cmp_big", 16'hFFFF, 16'h0000, 3'd7, 16'h0004);
    op("shl", 16'd256, 16'd2, 3'd3, 16'd1024);
    op("shr", 16'd64, 16'd3, 3'd4, 16'd8);
    op("shl_w", 16'd1, 16'd16, 3'd3, 16'd0);
`ifdef ALU_EXT_FLAGS_EN
    chk("shl_w_carry", 32'(carry_flag), 32'd1);
`endif
    op("shr_big", 16'h8000, 16'd20, 3'd4, 16'd0);
    op("shr_15", 16'h8000, 16'd15, 3'd4, 16'd1);
    op("sub_zero", 16'd45, 16'd45, 3'd1, 16'd0);
    idle(3);
    op("add_wrap", 16'hFFFF, 16'd1, 3'd0, 16'd0);
`ifdef ALU_EXT_FLAGS_EN
    chk("add_wrap_carry", 32'(carry_flag), 32'd1);
    chk("add_wrap_neg", 32'(neg_flag), 32'd0);
    chk("add_wrap_ovf", 32'(ovf_flag), 32'd0);
`endif
    op("add_ovf", 16'h7FFF, 16'd1, 3'd0, 16'h8000);
`ifdef ALU_EXT_FLAGS_EN
    chk("add_ovf_carry", 32'(carry_flag), 32'd0);
    chk("add_ovf_neg", 32'(neg_flag), 32'd1);
    chk("add_ovf_ovf", 32'(ovf_flag), 32'd1);
    idle(1);
    chk("ext_hold_neg", 32'(neg_flag), 32'd1);
    chk("ext_hold_ovf", 32'(ovf_flag), 32'd1);
`endif

    // Reset while a result is being presented discards it immediately.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'd3;
    b        = 16'd4;
    alu_sel  = 3'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst2_res", 32'(result), 32'd0);
    chk("rst2_zero", 32'(zero_flag), 32'd0);
    chk("rst2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_res", 32'(result), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
